// File: rtl/e203_tb_stim_pkg.sv
// Shared types and constants for the E203 interrupt stimulus / commit monitor.
// Holds the channel state encoding, the Galois LFSR tap table and per-channel seed derivation.
package e203_tb_stim_pkg;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_LOAD,
    CH_WAIT,
    CH_ACTIVE,
    CH_STOPPED
  } ch_state_e;

  // Right-shifting Galois masks for maximal-length sequences at common widths.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_B400;
    endcase
  endfunction

  function automatic logic [31:0] chan_seed(input logic [31:0] seed,
                                            input int unsigned ch,
                                            input int unsigned width);
    logic [31:0] wmask;
    logic [31:0] v;
    wmask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    v     = (seed ^ ((ch + 1) * 32'h0000_1D35)) & wmask;
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

endpackage

// File: rtl/e203_irq_stim_chan.sv
// One interrupt channel: LFSR-timed assertion, release on handler-PC commit.
// irq rises loaded-delay+1 edges after LOAD and falls on the edge sampling the ack commit.
module e203_irq_stim_chan
  import e203_tb_stim_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DLY_W = 16,
  parameter int unsigned CH    = 0,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             armed,
  input  logic             stop,
  input  logic             cmt_valid,
  input  logic [PC_W-1:0]  cmt_pc,
  input  logic [PC_W-1:0]  ack_pc,
  input  logic [DLY_W-1:0] dly_mask,
  output logic             irq
);

  localparam logic [DLY_W-1:0] TAPS     = DLY_W'(lfsr_taps(DLY_W));
  localparam logic [DLY_W-1:0] SEED_C   = DLY_W'(chan_seed({16'h0, SEED}, CH, DLY_W));
  localparam logic [DLY_W:0]   DCNT_ONE = {{DLY_W{1'b0}}, 1'b1};

  ch_state_e        state;
  logic [DLY_W-1:0] lfsr;
  logic [DLY_W-1:0] lfsr_nxt;
  // One extra bit so an all-ones mask plus one does not wrap to zero.
  logic [DLY_W:0]   dcnt;
  logic             ack_hit;

  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign ack_hit  = cmt_valid && (cmt_pc == ack_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_IDLE;
      lfsr  <= SEED_C;
      dcnt  <= '0;
      irq   <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        CH_IDLE: begin
          if (armed && en && !stop) state <= CH_LOAD;
        end
        CH_LOAD: begin
          if (!en) begin
            state <= CH_IDLE;
          end else begin
            dcnt  <= {1'b0, lfsr & dly_mask} + DCNT_ONE;
            state <= CH_WAIT;
          end
        end
        CH_WAIT: begin
          if (!en) begin
            state <= CH_IDLE;
          end else if (dcnt == DCNT_ONE) begin
            irq   <= 1'b1;
            state <= CH_ACTIVE;
          end else begin
            dcnt <= dcnt - DCNT_ONE;
          end
        end
        CH_ACTIVE: begin
          // The handler must finish even when disabled; en only decides what follows.
          if (ack_hit) begin
            irq <= 1'b0;
            if (stop)     state <= CH_STOPPED;
            else if (en)  state <= CH_LOAD;
            else          state <= CH_IDLE;
          end
        end
        CH_STOPPED: begin
          irq <= 1'b0;
        end
        default: begin
          state <= CH_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/e203_irq_stim_mon.sv
// Commit-stream monitor (cycles, retired, tohost, done) driving NCH LFSR-timed interrupt channels.
// All outputs registered; done rises one edge after the last irq release once enough tohost commits are seen.
module e203_irq_stim_mon
  import e203_tb_stim_pkg::*;
#(
  parameter int unsigned NCH      = 3,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned DLY_W    = 16,
  parameter int unsigned STOP_CNT = 32,
  parameter int unsigned END_CNT  = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cmt_valid,
  input  logic [PC_W-1:0]      cmt_pc,
  input  logic [PC_W-1:0]      start_pc,
  input  logic [PC_W-1:0]      tohost_pc,
  input  logic [NCH*PC_W-1:0]  ack_pc,
  input  logic [NCH*DLY_W-1:0] dly_mask,
  output logic [NCH-1:0]       irq,
  output logic                 armed,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instret_cnt,
  output logic [31:0]          tohost_cnt,
  output logic [31:0]          end_cycle,
  output logic                 done
);

  logic tohost_hit;
  logic start_hit;
  logic stop;

  assign tohost_hit = cmt_valid && (cmt_pc == tohost_pc);
  assign start_hit  = cmt_valid && (cmt_pc == start_pc);
  // Uses the pre-increment count, so the commit crossing the threshold still re-arms.
  assign stop       = (tohost_cnt > STOP_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      tohost_cnt  <= '0;
      end_cycle   <= '0;
      armed       <= 1'b0;
      done        <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (cmt_valid && (tohost_cnt == 32'd0)) instret_cnt <= instret_cnt + 32'd1;
      if (tohost_hit) begin
        tohost_cnt <= tohost_cnt + 32'd1;
        if (tohost_cnt == 32'd0) end_cycle <= cycle_cnt;
      end
      if (start_hit) armed <= 1'b1;
      if ((tohost_cnt >= END_CNT) && (irq == '0)) done <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    e203_irq_stim_chan #(
      .PC_W  (PC_W),
      .DLY_W (DLY_W),
      .CH    (c),
      .SEED  (SEED)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .armed     (armed),
      .stop      (stop),
      .cmt_valid (cmt_valid),
      .cmt_pc    (cmt_pc),
      .ack_pc    (ack_pc[c*PC_W +: PC_W]),
      .dly_mask  (dly_mask[c*DLY_W +: DLY_W]),
      .irq       (irq[c])
    );
  end

endmodule

// File: tb/tb_e203_irq_stim_mon.sv
// Directed bench for e203_irq_stim_mon (NCH=3): counters, irq timing, stop/done, simultaneous events, reset.
`timescale 1ns/1ps
module tb_e203_irq_stim_mon;

  localparam logic [31:0] START  = 32'h8000_015C;
  localparam logic [31:0] TOHOST = 32'h8000_0086;
  localparam logic [31:0] ACK0   = 32'h8000_00A6;
  localparam logic [31:0] ACK1   = 32'h8000_00B0;
  localparam logic [31:0] ACK2   = 32'h8000_00C0;
  localparam logic [31:0] ACKX   = 32'h8000_00D0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic [31:0] start_pc = START;
  logic [31:0] tohost_pc = TOHOST;
  logic [95:0] ack_pc = {ACK2, ACK1, ACK0};
  logic [47:0] dly_mask = '0;
  logic [2:0]  irq;
  logic        armed;
  logic [31:0] cycle_cnt, instret_cnt, tohost_cnt, end_cycle;
  logic        done;

  e203_irq_stim_mon dut (
    .clk(clk), .rst(rst), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .start_pc(start_pc), .tohost_pc(tohost_pc), .ack_pc(ack_pc), .dly_mask(dly_mask),
    .irq(irq), .armed(armed), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .tohost_cnt(tohost_cnt), .end_cycle(end_cycle), .done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ecount = 0;
  int          n_cmt = 0;
  bit          seen_th = 1'b0;
  logic [31:0] exp_end = '0;
  logic [31:0] exp_instret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) ecount = 0;
    else     ecount++;
  endtask

  task automatic commit(input logic [31:0] pc);
    if (!seen_th) n_cmt++;
    if (!seen_th && pc == TOHOST) begin
      seen_th     = 1'b1;
      exp_end     = ecount;
      exp_instret = n_cmt;
    end
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    step();
    cmt_valid = 1'b0;
    cmt_pc    = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst     = 1'b0;
    n_cmt   = 0;
    seen_th = 1'b0;
  endtask

  function automatic logic [31:0] ack_of(input int c);
    return (c == 0) ? ACK0 : (c == 1) ? ACK1 : ACK2;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          sel;
    int          hi[3];
    int          gap[3];
    bit          gvld[3];
    bit          acked[3];
    logic [2:0]  prev;
    int          acks, budget, min_gap, max_gap;

    // Reset hold and idle period
    do_reset(5);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_armed", 32'(armed), 32'h0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_done", 32'(done), 32'h0);
    for (int i = 0; i < 100; i++) step();
    chk("idle_cycle", cycle_cnt, 32'd100);
    chk("idle_instret", instret_cnt, 32'd0);
    chk("idle_irq", 32'(irq), 32'h0);
    chk("idle_armed", 32'(armed), 32'h0);

    // Arm with mask 0: irq three edges after the start commit
    commit(START);
    chk("arm_armed", 32'(armed), 32'h1);
    chk("arm_instret", instret_cnt, 32'd1);
    chk("arm_irq_e0", 32'(irq), 32'h0);
    step(); chk("arm_irq_e1", 32'(irq), 32'h0);
    step(); chk("arm_irq_e2", 32'(irq), 32'h0);
    step(); chk("arm_irq_e3", 32'(irq), 32'h7);
    for (int i = 0; i < 5; i++) step();
    chk("held_irq", 32'(irq), 32'h7);
    commit(ACK0); chk("ack0_drop", 32'(irq), 32'h6);
    step();       chk("ack0_a1", 32'(irq), 32'h6);
    step();       chk("ack0_rearm", 32'(irq), 32'h7);

    // Randomised delays with mask 0x3FF: ack each channel ~5 edges after rise
    dly_mask = {3{16'h03FF}};
    for (int c = 0; c < 3; c++) begin hi[c] = 0; gap[c] = 0; gvld[c] = 1'b0; end
    prev = irq; acks = 0; budget = 0; min_gap = 100000; max_gap = 0;
    while (acks < 200 && budget < 60000) begin
      sel = -1;
      for (int c = 0; c < 3; c++) if (irq[c] && hi[c] >= 5 && sel < 0) sel = c;
      if (sel >= 0) commit(ack_of(sel)); else step();
      budget++;
      for (int c = 0; c < 3; c++) begin
        if (c == sel) begin
          chk("rand_drop", 32'(irq[c]), 32'h0);
          hi[c] = 0; gap[c] = 0; gvld[c] = 1'b1; acks++;
        end else begin
          gap[c]++;
          if (sel >= 0 && prev[c]) chk("rand_hold", 32'(irq[c]), 32'h1);
          if (irq[c] && !prev[c]) begin
            if (gvld[c]) begin
              chk("rand_dly_range", 32'(gap[c] >= 2 && gap[c] <= 1025), 32'h1);
              if (gap[c] < min_gap) min_gap = gap[c];
              if (gap[c] > max_gap) max_gap = gap[c];
            end
            hi[c] = 0;
          end else if (irq[c]) begin
            hi[c]++;
          end
        end
      end
      prev = irq;
    end
    chk("rand_budget", 32'(acks >= 200), 32'h1);
    chk("rand_spread", 32'(max_gap > min_gap + 100), 32'h1);

    // 33 tohost commits interleaved with acks, then drain into STOPPED
    dly_mask = '0;
    chk("pre_tohost_done", 32'(done), 32'h0);
    for (int i = 0; i < 33; i++) begin
      commit(TOHOST);
      if (i == 6) chk("done_early", 32'(done), 32'h0);
      sel = -1;
      for (int c = 0; c < 3; c++) if (irq[c] && sel < 0) sel = c;
      if (sel >= 0) commit(ack_of(sel)); else step();
    end
    chk("stop_tohost", tohost_cnt, 32'd33);
    for (int c = 0; c < 3; c++) acked[c] = 1'b0;
    budget = 0;
    while (!(acked[0] && acked[1] && acked[2]) && budget < 3000) begin
      sel = -1;
      for (int c = 0; c < 3; c++) if (irq[c] && sel < 0) sel = c;
      if (sel >= 0) begin commit(ack_of(sel)); acked[sel] = 1'b1; end
      else step();
      budget++;
    end
    chk("drain_budget", 32'(acked[0] && acked[1] && acked[2]), 32'h1);
    for (int i = 0; i < 40; i++) step();
    chk("stopped_irq", 32'(irq), 32'h0);
    chk("end_done", 32'(done), 32'h1);
    chk("end_cycle", end_cycle, exp_end);
    chk("end_instret", instret_cnt, exp_instret);
    chk("end_tohost", tohost_cnt, 32'd33);

    // Fresh run: en=0 during ACTIVE, multi-ack, tohost+ack on one commit
    do_reset(2);
    commit(START);
    step(); step(); step();
    chk("r2_irq", 32'(irq), 32'h7);
    en = 1'b0;
    commit(ACK0); chk("en0_drop", 32'(irq), 32'h6);
    for (int i = 0; i < 5; i++) step();
    chk("en0_idle", 32'(irq), 32'h6);
    en = 1'b1;
    step(); step(); chk("en1_a2", 32'(irq), 32'h6);
    step();         chk("en1_rise", 32'(irq), 32'h7);
    ack_pc[31:0]  = ACKX;
    ack_pc[95:64] = ACKX;
    commit(ACKX); chk("multi_ack", 32'(irq), 32'h2);
    step(); step(); chk("multi_rearm", 32'(irq), 32'h7);
    ack_pc[63:32] = TOHOST;
    commit(TOHOST);
    chk("th_ack_irq", 32'(irq), 32'h5);
    chk("th_ack_cnt", tohost_cnt, 32'd1);
    chk("th_ack_end", end_cycle, exp_end);

    // One-cycle reset with irq=101
    rst = 1'b1; step(); rst = 1'b0; n_cmt = 0; seen_th = 1'b0;
    chk("rst1_irq", 32'(irq), 32'h0);
    chk("rst1_armed", 32'(armed), 32'h0);
    chk("rst1_cycle", cycle_cnt, 32'd0);
    chk("rst1_instret", instret_cnt, 32'd0);
    chk("rst1_tohost", tohost_cnt, 32'd0);
    chk("rst1_end", end_cycle, 32'd0);
    chk("rst1_done", 32'(done), 32'h0);
    ack_pc = {ACK2, ACK1, ACK0};
    for (int i = 0; i < 10; i++) step();
    chk("rst1_noarm_irq", 32'(irq), 32'h0);
    chk("rst1_cycle10", cycle_cnt, 32'd10);
    commit(START);
    step(); step(); step();
    chk("rst1_rearm", 32'(irq), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/e203_irq_stim_mon.md
Name: e203_irq_stim_mon

Overview:
- Parametrised interrupt-stimulus generator and commit monitor for E203 SoC simulation benches.
- Watches the EXU commit stream (valid + PC) and counts cycles, retired instructions and test-end ("tohost") commits.
- Drives NCH interrupt lines. Each line is asserted after a pseudo-random delay and released when its handler PC commits.
- Replaces free-running bench stimulus with a clocked, reset-able block. It supports any channel count, per-channel delay masks, a stop threshold and a sticky done flag.

Parameters:
- NCH, 3, number of interrupt channels (1..8).
- PC_W, 32, commit PC width (matches E203_PC_SIZE).
- DLY_W, 16, width of delay counter, LFSR and delay mask.
- STOP_CNT, 32, stop re-arming channels once tohost_cnt > STOP_CNT.
- END_CNT, 8, tohost_cnt value that qualifies done.
- SEED, 16'hACE1, base LFSR seed. Channel c seeds with SEED ^ (c+1)*16'h1D35, forced to 1 if the result is 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  stimulus enable. Counters run regardless of en.
- cmt_valid  in  1  commit valid.
- cmt_pc  in  PC_W  committed PC.
- start_pc  in  PC_W  PC whose commit arms stimulus.
- tohost_pc  in  PC_W  PC whose commit counts as test end.
- ack_pc  in  NCH*PC_W  per-channel handler PC (slice c = channel c).
- dly_mask  in  NCH*DLY_W  per-channel delay mask.
- irq  out  NCH  interrupt lines.
- armed  out  1  sticky; set on first commit of start_pc.
- cycle_cnt  out  32  cycles since reset.
- instret_cnt  out  32  commits before first tohost.
- tohost_cnt  out  32  tohost commits.
- end_cycle  out  32  cycle_cnt value at first tohost commit.
- done  out  1  sticky end-of-test flag.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): all outputs 0, all channel FSMs in IDLE, LFSRs reloaded with their seeds. Reset mid-operation drops any asserted irq on the next edge.
- cycle_cnt: +1 every cycle, wraps at 2^32.
- instret_cnt: +1 on each cmt_valid while no tohost commit has been seen.
- tohost hit = cmt_valid & (cmt_pc==tohost_pc).
  - On a hit: tohost_cnt +1.
  - On the first hit (tohost_cnt==0): end_cycle <= cycle_cnt, sampled before its own increment.
  - The commit that is the first hit still counts in instret_cnt.
- armed: set when cmt_valid & cmt_pc==start_pc. Never cleared except by reset.
- stop = (tohost_cnt > STOP_CNT), combinational.
- LFSR per channel: 16-bit Galois, mask 16'hB400, shift right, advances every cycle after reset. Width DLY_W; taps table in package.
- Per-channel FSM, all outputs registered:
  - IDLE: irq=0. If armed & en & !stop -> LOAD.
  - LOAD: dcnt <= (lfsr & dly_mask_c) + 1. Minimum 1, maximum mask+1; mask 0 gives delay 1. -> WAIT.
  - WAIT: dcnt -1 each cycle. When dcnt==1: irq_c <= 1 -> ACTIVE.
  - ACTIVE: irq_c held at 1. On cmt_valid & cmt_pc==ack_pc_c: irq_c <= 0, then -> STOPPED if stop, else -> LOAD.
  - STOPPED: irq=0. Terminal until reset.
- Latency: irq rises exactly dcnt_loaded+1 cycles after the LOAD cycle, and falls on the edge following the acking commit.
- en=0 in LOAD or WAIT: -> IDLE. en=0 in ACTIVE: irq held until ack (the handler must complete), then -> IDLE.
- Simultaneous events:
  - A commit that is both tohost and ack for a channel is processed for both.
  - stop is evaluated with the pre-increment tohost_cnt.
  - One commit matching several ack_pc values releases all matching channels.
- done: set when tohost_cnt >= END_CNT and irq == 0 (all channels). Sticky. May coincide with an irq-release edge only if computed from the registered irq, so it rises one cycle after the last release.
- Counters do not saturate. Wrap is not checked.

Decomposition:
- Package e203_tb_stim_pkg: channel state enum (IDLE, LOAD, WAIT, ACTIVE, STOPPED), LFSR tap constants per width, seed-derivation function.
- One sub-module e203_irq_stim_chan: one channel, holding the FSM, LFSR and delay counter. Instantiated NCH times by generate. The top level holds the shared counters, armed, stop and done.

Test Plan:
- Reset hold 5 cycles, then no commits for 100 cycles -> irq=0, armed=0, cycle_cnt=100, instret_cnt=0.
- NCH=1, dly_mask=0, commit start_pc=0x8000015C at cycle 10 -> irq[0] rises at cycle 13; commit ack_pc=0x800000A6 at cycle 20 -> irq[0]=0 at cycle 21, re-asserts at cycle 23.
- NCH=3, masks 0x3FF, ack each channel by PC 5 cycles after its rise, 200 iterations -> every delay in [1,1024], no irq held after ack+1, channels independent.
- 33 tohost commits (tohost_pc=0x80000086) interleaved with acks -> after tohost_cnt=33 each channel ends in STOPPED; end_cycle equals the cycle of the first tohost; done set when tohost_cnt>=8 and irq==0.
- One commit matching tohost_pc and ack_pc[1] (set equal) while channel 1 is ACTIVE -> tohost_cnt +1 and irq[1] drops on the same edge.
- rst pulsed for 1 cycle while irq=3'b101 -> next edge all outputs 0; stimulus restarts only after start_pc is committed again.
